hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the IF/ID and ID/EX pipeline registers and tracks the destination registers of the instructions in EX, MEM and WB. It drives the PC/IF_ID stall, the IF_ID flush and the ID_EX `stop` bubble input, and produces the operand-forwarding selects for EX. It resolves three hazard classes: load-use, EX-stage redirect, and RAW forwarding.

## Interface
Parameters:
- `XLEN`, 32, counter width for performance counters.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`  in  5 each  ID source register indices
- `id_re1`, `id_re2`  in  1 each  ID instruction reads rs1 / rs2
- `id_rf_we`  in  1  ID instruction writes the register file
- `id_wR`  in  5  ID destination index
- `id_is_load`  in  1  ID instruction is a load (wd_sel = DRAM)
- `ex_redirect`  in  1  branch taken or jump resolved in EX this cycle
- `pc_stall`  out  1  hold PC
- `if_id_stall`  out  1  hold IF/ID
- `if_id_flush`  out  1  clear IF/ID to a bubble
- `id_ex_stop`  out  1  insert a bubble into ID/EX (drives `stop`)
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back value, 11 WB-stage register-file write data
- `stall_cnt`, `flush_cnt`  out  XLEN each  present only with `HAZ_PERF_CNT_EN`

## Operation
- **Scoreboard** (registered): each entry holds {we, wR, load} for EX, MEM and WB.
  - Every clk: EX entry ← {id_rf_we & id_valid, id_wR, id_is_load}, or zeros if `id_ex_stop`. MEM ← EX, WB ← MEM.
  - An entry with wR = 0 never matches.
- **Forwarding** (combinational, per operand):
  - 01 if the EX entry matches, we = 1 and load = 0.
  - else 10 if the MEM entry matches with we = 1 (load data included).
  - else 11 if the WB entry matches with we = 1.
  - else 00.
  - The operand must be read (`re`) for any non-zero select. EX has priority over MEM, MEM over WB.
- **Load-use**: `lu` = id_valid & EX.load & EX.we & EX.wR≠0 & ((id_re1 & rs1 = EX.wR) | (id_re2 & rs2 = EX.wR)).
  - Response: pc_stall = if_id_stall = id_ex_stop = 1 for exactly one cycle.
- **Redirect**: `ex_redirect` gives if_id_flush = id_ex_stop = 1 and pc_stall = if_id_stall = 0 in the same cycle.
- **Simultaneous redirect and lu**: redirect wins, because the ID instruction is wrong-path. No stall; lu is ignored.
- **FSM** (2 states, registered):
  - RUN: normal operation. lu & !ex_redirect → BUBBLE.
  - BUBBLE: the EX entry is a bubble, so lu is necessarily 0. Always → RUN.
  - The FSM is a checker and counter qualifier only; outputs are decoded from inputs and scoreboard.
- **Reset**:
  - All scoreboard entries = 0; state = RUN; counters = 0.
  - Outputs pc_stall, if_id_stall, if_id_flush, id_ex_stop = 0 and fwd_a = fwd_b = 00 while rst_n is low.
  - Reset mid-stall drops the stall immediately (asynchronous).

## Timing
- Stall/flush/forward outputs are combinational from the current ID inputs and registered scoreboard. No added latency: they act on the next clk edge.
- Load-use penalty: 1 cycle. After the bubble the load sits in MEM, and the dependent instruction gets fwd = 10.
- Redirect penalty: 2 instructions (IF and ID) squashed in one cycle.
- Back-to-back redirects on consecutive cycles each flush independently.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every RUN→BUBBLE transition.
  - `flush_cnt` increments on every cycle with `ex_redirect`.
  - Both wrap modulo 2^XLEN and reset to 0.
- `HAZ_PERF_CNT_EN` undefined: counter ports and registers are absent. All other behaviour is identical.

## Structure
- **`hazard_pkg`**:
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, FWD_WB = 2'b11.
  - State encoding RUN = 1'b0, BUBBLE = 1'b1.
  - Scoreboard entry struct {we, wR[4:0], load}.
- **Sub-module `hazard_fwd_sel`**: combinational match/priority logic for one operand, instantiated twice (rs1 → fwd_a, rs2 → fwd_b).

## Test plan
- **Forwarding priority**: `addi x5` then `add x6,x5,x5` in ID → fwd_a = fwd_b = 01, no stall. Three `addi x5` back-to-back, then a reader → 01 (EX beats MEM and WB).
- **Load-use**: `lw x7` in EX, `add x8,x7,x0` in ID → pc_stall = if_id_stall = id_ex_stop = 1 for one cycle. Next cycle state = BUBBLE, stall = 0, fwd_a = 10.
- **Redirect vs load-use**: ex_redirect = 1 together with a lu condition → if_id_flush = 1, id_ex_stop = 1, pc_stall = 0. EX entry = zeros next cycle.
- **x0 / no-read**: writer to x0 followed by a reader of x0 → fwd = 00, no stall. Reader with id_re2 = 0 and a matching rs2 → fwd_b = 00.
- **Reset mid-stall**: assert rst_n = 0 during the lu cycle → all outputs 0 immediately, state RUN, scoreboard cleared, counters 0.
- **Perf counters** (with `HAZ_PERF_CNT_EN`): 3 load-use events and 2 redirects → stall_cnt = 3, flush_cnt = 2. Preload flush_cnt to 0xFFFFFFFF, then one redirect → 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // EX operand select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } haz_state_e;

  // One in-flight instruction's register-file write intent
  typedef struct packed {
    logic       we;
    logic [4:0] wr;
    logic       load;
  } sb_entry_t;

  // x0 is hard-wired, so a write to it never produces a dependency
  function automatic logic sb_hit(sb_entry_t e, logic [4:0] idx);
    return e.we && (e.wr != 5'd0) && (e.wr == idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one EX source operand (EX > MEM > WB priority).
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       re_i,
  input  sb_entry_t  ex_i,
  input  sb_entry_t  mem_i,
  input  sb_entry_t  wb_i,
  output logic [1:0] sel_o
);

  // Load data is not available from EX, so a load in EX cannot forward
  logic unused_load;
  assign unused_load = mem_i.load ^ wb_i.load;

  // Priority match of the operand against the younger-to-older pipeline entries
  always_comb begin
    sel_o = FWD_RF;
    if (re_i) begin
      if (sb_hit(ex_i, rs_i) && !ex_i.load) begin
        sel_o = FWD_EXMEM;
      end else if (sb_hit(mem_i, rs_i)) begin
        sel_o = FWD_MEMWB;
      end else if (sb_hit(wb_i, rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, RAW forwarding selects.
// Optional performance counters (stall_cnt, flush_cnt) built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_re1,
  input  logic            id_re2,
  input  logic            id_rf_we,
  input  logic [4:0]      id_wR,
  input  logic            id_is_load,
  input  logic            ex_redirect,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_stop,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] flush_cnt
`endif
);

  sb_entry_t  sb_ex_q, sb_ex_d;
  sb_entry_t  sb_mem_q, sb_mem_d;
  sb_entry_t  sb_wb_q, sb_wb_d;
  haz_state_e state_q, state_d;

  logic       lu;
  logic       stall_raw;
  logic       stop_raw;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  hazard_fwd_sel u_fwd_a (
    .rs_i  (id_rs1),
    .re_i  (id_re1),
    .ex_i  (sb_ex_q),
    .mem_i (sb_mem_q),
    .wb_i  (sb_wb_q),
    .sel_o (fwd_a_raw)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_i  (id_rs2),
    .re_i  (id_re2),
    .ex_i  (sb_ex_q),
    .mem_i (sb_mem_q),
    .wb_i  (sb_wb_q),
    .sel_o (fwd_b_raw)
  );

  // Hazard decode; outputs are forced idle while reset is asserted
  always_comb begin
    lu = id_valid && sb_ex_q.load && sb_ex_q.we && (sb_ex_q.wr != 5'd0) &&
         ((id_re1 && (id_rs1 == sb_ex_q.wr)) || (id_re2 && (id_rs2 == sb_ex_q.wr)));
    // A redirect squashes the ID instruction, so its load-use is moot
    stall_raw   = lu && !ex_redirect;
    stop_raw    = stall_raw || ex_redirect;
    pc_stall    = rst_n && stall_raw;
    if_id_stall = rst_n && stall_raw;
    if_id_flush = rst_n && ex_redirect;
    id_ex_stop  = rst_n && stop_raw;
    fwd_a       = rst_n ? fwd_a_raw : FWD_RF;
    fwd_b       = rst_n ? fwd_b_raw : FWD_RF;
  end

  // Scoreboard shift and FSM next state
  always_comb begin
    sb_ex_d  = '0;
    sb_mem_d = sb_ex_q;
    sb_wb_d  = sb_mem_q;
    if (!stop_raw) begin
      sb_ex_d.we   = id_rf_we && id_valid;
      sb_ex_d.wr   = id_wR;
      sb_ex_d.load = id_is_load;
    end
    state_d = state_q;
    unique case (state_q)
      RUN:     if (stall_raw) state_d = BUBBLE;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Scoreboard and FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
      state_q  <= RUN;
    end else begin
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_wb_d;
      state_q  <= state_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

  // Event counters, wrapping naturally at 2^XLEN
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == RUN) && (state_d == BUBBLE)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ex_redirect) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  localparam int unsigned UnusedXlen = XLEN;
`endif

endmodule
